// File: rtl/param_input_pio.sv
// param_input_pio
//   Avalon-MM slave input PIO for the reverb control front panel. It samples a
//   WIDTH-bit bank of asynchronous inputs (parameter-select switches, encoder
//   push buttons) through a 2-FF synchroniser. Each bit has an edge-capture
//   flag, and an interrupt mask lets the Nios control loop react to changes
//   without polling.
//
//   Optional feature: define DEBOUNCE_EN to add a per-bit stability filter of
//   DEBOUNCE_CYCLES clocks between the synchroniser and the edge detector.
//
//   Register map (word address):
//     0 data         : synchronised (or debounced) inputs, read-only
//     1 reserved     : reads 0, writes ignored
//     2 irq_mask     : read/write, bits [WIDTH-1:0]
//     3 edge_capture : read, write-1-to-clear
//
//   Ports:
//     clk        system clock
//     reset      asynchronous, active-high reset
//     address    Avalon word address
//     chipselect slave select
//     write_n    active-low write strobe (qualified by chipselect)
//     writedata  write data (bits above WIDTH ignored)
//     in_port    asynchronous external inputs
//     readdata   registered read data, 1-cycle latency, updated every cycle
//     irq        level interrupt, |(edge_capture & irq_mask)
module param_input_pio #(
   parameter int          WIDTH           = 4,
   parameter int          EDGE_TYPE       = 0,
   parameter logic [31:0] IRQ_MASK_RESET  = 32'h0,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] v;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] edge_vec;
   logic [WIDTH-1:0] clear_vec;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] irq_mask;
   logic [31:0]      rd_next;
   logic             wr_en;
   logic             writedata_unused;

   assign wr_en = chipselect & ~write_n;

   // Only the low WIDTH bits of writedata are stored anywhere.
   assign writedata_unused = ^writedata;

   // Two-stage synchroniser for the asynchronous panel inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in_port;
         s2 <= s1;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic [WIDTH-1:0] db;
   logic [CW-1:0]    cnt [WIDTH];

   // A bit's debounced value follows s2 only after s2 has disagreed with it
   // for DEBOUNCE_CYCLES consecutive clocks; any agreement restarts the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] != db[i]) begin
               if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                  db[i]  <= s2[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end

   assign v = db;
`else
   logic [31:0] db_cycles_unused;

   assign db_cycles_unused = 32'(DEBOUNCE_CYCLES);
   assign v = s2;
`endif

   always_comb begin
      edge_vec = '0;
      case (EDGE_TYPE)
         0:       edge_vec = v & ~prev;
         1:       edge_vec = ~v & prev;
         default: edge_vec = v ^ prev;
      endcase
   end

   assign clear_vec = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

   // Set is OR-ed in after the clear, so a capture in the same cycle as a
   // clear of that bit leaves it set and the event is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev         <= '0;
         edge_capture <= '0;
         irq_mask     <= IRQ_MASK_RESET[WIDTH-1:0];
      end else begin
         prev         <= v;
         edge_capture <= (edge_capture & ~clear_vec) | edge_vec;
         if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // Read mux is evaluated from the pre-update register values, so a read of
   // edge_capture racing a capture returns the old value.
   always_comb begin
      rd_next = '0;
      case (address)
         2'd0:    rd_next[WIDTH-1:0] = v;
         2'd1:    rd_next = '0;
         2'd2:    rd_next[WIDTH-1:0] = irq_mask;
         default: rd_next[WIDTH-1:0] = edge_capture;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= '0;
      else       readdata <= rd_next;
   end

   assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_param_input_pio.sv
// tb_param_input_pio
//   Three instances (rising, falling, any-edge capture) share one bus and one
//   input bank. A queue-based model predicts readdata and irq for each one and
//   a compare process checks them every cycle; literal checks pin the model.
module tb_param_input_pio;

   localparam int W = 4;
`ifdef DEBOUNCE_EN
   localparam int DC = 16;
`endif

   logic         clk        = 1'b0;
   logic         reset      = 1'b1;
   logic [1:0]   address    = '0;
   logic         chipselect = 1'b0;
   logic         write_n    = 1'b1;
   logic [31:0]  writedata  = '0;
   logic [W-1:0] in_port    = '0;
   logic [31:0]  rd [3];
   logic [2:0]   irq_w;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mrst(int e);
      case (e)
         0:       return 32'h0;
         1:       return 32'h5;
         default: return 32'hA;
      endcase
   endfunction

   for (genvar e = 0; e < 3; e++) begin : g_dut
      param_input_pio #(
         .WIDTH(W),
         .EDGE_TYPE(e),
         .IRQ_MASK_RESET(mrst(e)),
         .DEBOUNCE_CYCLES(16)
      ) u_dut (
         .clk(clk),
         .reset(reset),
         .address(address),
         .chipselect(chipselect),
         .write_n(write_n),
         .writedata(writedata),
         .in_port(in_port),
         .readdata(rd[e]),
         .irq(irq_w[e])
      );
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [W-1:0] m_pipe [$];   // [0] = value visible after the synchroniser
   logic [W-1:0] m_prev [3];
   logic [W-1:0] m_cap  [3];
   logic [W-1:0] m_mask [3];
   logic [31:0]  m_rd   [3];
`ifdef DEBOUNCE_EN
   logic [W-1:0] m_db;
   logic [W-1:0] m_hist [$];   // last DC synchronised samples
`endif

   always @(posedge clk or posedge reset) begin
      logic [W-1:0] v_now;
      logic [W-1:0] ev;
      logic [W-1:0] clr;
      bit           wr;
      bit           all_diff;
      if (reset) begin
         m_pipe = {};
         m_pipe.push_back('0);
         m_pipe.push_back('0);
`ifdef DEBOUNCE_EN
         m_db   = '0;
         m_hist = {};
`endif
         for (int e = 0; e < 3; e++) begin
            m_prev[e] = '0;
            m_cap[e]  = '0;
            m_mask[e] = mrst(e);
            m_rd[e]   = '0;
         end
      end else begin
`ifdef DEBOUNCE_EN
         v_now = m_db;
`else
         v_now = m_pipe[0];
`endif
         wr  = chipselect && !write_n;
         clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
         for (int e = 0; e < 3; e++) begin
            case (e)
               0:       ev = v_now & ~m_prev[e];
               1:       ev = ~v_now & m_prev[e];
               default: ev = v_now ^ m_prev[e];
            endcase
            case (address)
               2'd0:    m_rd[e] = 32'(v_now);
               2'd1:    m_rd[e] = 32'h0;
               2'd2:    m_rd[e] = 32'(m_mask[e]);
               default: m_rd[e] = 32'(m_cap[e]);
            endcase
            m_cap[e] = (m_cap[e] & ~clr) | ev;
            if (wr && address == 2'd2) m_mask[e] = writedata[W-1:0];
            m_prev[e] = v_now;
         end
`ifdef DEBOUNCE_EN
         m_hist.push_back(m_pipe[0]);
         if (m_hist.size() > DC) void'(m_hist.pop_front());
         if (m_hist.size() == DC) begin
            for (int b = 0; b < W; b++) begin
               all_diff = 1'b1;
               for (int k = 0; k < DC; k++)
                  if (m_hist[k][b] == m_db[b]) all_diff = 1'b0;
               if (all_diff) m_db[b] = ~m_db[b];
            end
         end
`endif
         m_pipe.push_back(in_port);
         void'(m_pipe.pop_front());
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && !reset) begin
         for (int e = 0; e < 3; e++) begin
            check($sformatf("model_readdata%0d", e), rd[e], m_rd[e]);
            check($sformatf("model_irq%0d", e), {31'b0, irq_w[e]},
                  {31'b0, |(m_cap[e] & m_mask[e])});
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at a negedge: the access is presented for the next posedge.
   task automatic do_write(logic [1:0] a, logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic do_read(int e, logic [1:0] a, logic [31:0] exp, string name);
      address = a;
      @(negedge clk);
      check(name, rd[e], exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      in_port = 4'b1010;
      reset   = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_readdata", rd[0], 32'h0);
      check("reset_irq", {31'b0, irq_w[0]}, 32'h0);
      reset  = 1'b0;
      chk_en = 1'b1;

`ifndef DEBOUNCE_EN
      address = 2'd0;
      repeat (4) @(negedge clk);
      check("data_1010", rd[0], 32'h0000000A);

      do_write(2'd3, 32'hF);
      do_write(2'd2, 32'h1);
      in_port = 4'b1011;
      repeat (4) @(negedge clk);
      check("rise_irq_set", {31'b0, irq_w[0]}, 32'h1);
      do_read(0, 2'd3, 32'h1, "rise_cap_bit0");
      do_write(2'd3, 32'h1);
      check("rise_irq_clear", {31'b0, irq_w[0]}, 32'h0);

      // bit2 rises so its capture coincides with a clear of bit2
      in_port = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      do_write(2'd3, 32'h4);
      do_read(0, 2'd3, 32'h4, "set_beats_clear");

      do_write(2'd3, 32'hF);
      do_write(2'd2, 32'h0);
      in_port[3] = 1'b0;
      repeat (3) @(negedge clk);
      in_port[3] = 1'b1;
      repeat (5) @(negedge clk);
      check("any_irq_masked", {31'b0, irq_w[2]}, 32'h0);
      do_read(2, 2'd3, 32'h8, "any_cap_bit3");
      do_write(2'd2, 32'hFFFFFFFF);
      check("any_irq_unmasked", {31'b0, irq_w[2]}, 32'h1);
      do_read(2, 2'd2, 32'h0000000F, "mask_readback");
`else
      repeat (40) @(negedge clk);
      in_port = '0;
      repeat (40) @(negedge clk);
      do_write(2'd3, 32'hF);
      in_port[1] = 1'b1;
      repeat (10) @(negedge clk);
      in_port[1] = 1'b0;
      repeat (30) @(negedge clk);
      do_read(0, 2'd3, 32'h0, "glitch_no_cap");
      do_read(0, 2'd0, 32'h0, "glitch_data");
      in_port[1] = 1'b1;
      repeat (15) @(negedge clk);
      check("db_not_yet", rd[0], 32'h0);
      repeat (5) @(negedge clk);
      check("db_settled", rd[0], 32'h2);
`endif

      // randomized bus traffic and input activity
      repeat (500) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) in_port = W'($urandom_range(0, 15));
         chipselect = 1'($urandom_range(0, 1));
         write_n    = 1'($urandom_range(0, 1));
         address    = 2'($urandom_range(0, 3));
         writedata  = $urandom;
      end
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;

      // fill every capture bit, then hit reset between clock edges
      do_write(2'd2, 32'hF);
      in_port = '0;
      repeat (40) @(negedge clk);
      in_port = 4'hF;
      repeat (40) @(negedge clk);
      check("pre_reset_irq", {31'b0, irq_w[0]}, 32'h1);
      do_read(0, 2'd3, 32'hF, "pre_reset_cap");
      #2 reset = 1'b1;
      #1;
      for (int e = 0; e < 3; e++) begin
         check($sformatf("async_rd%0d", e), rd[e], 32'h0);
         check($sformatf("async_irq%0d", e), {31'b0, irq_w[e]}, 32'h0);
      end
      @(negedge clk);
      @(negedge clk);
      reset   = 1'b0;
      address = 2'd2;
      @(negedge clk);
      for (int e = 0; e < 3; e++)
         check($sformatf("mask_reset%0d", e), rd[e], mrst(e));
      repeat (10) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
